// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch-side initiator for the instruction memory / I-cache port. Holds the
// program counter, issues word-aligned read requests (one outstanding at a
// time), collects in-order responses into a small FIFO and hands
// {pc, instruction} to decode over a valid/ready handshake. A redirect from
// branch resolution flushes the FIFO and restarts fetch at the new address.
//
// Optional feature: define IFU_PERF_CNT_EN to add the perf_fetches and
// perf_flushes counter outputs. Without it the ports and counters are absent.
//
// Parameters:
//   RESET_PC   first fetch address after reset (bits [1:0] ignored)
//   BUF_DEPTH  instruction buffer entries (power of two, >= 2)
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   mem_req, mem_addr     fetch request valid / word-aligned byte address
//   mem_ready             memory accepts request when mem_req && mem_ready
//   mem_rvalid, mem_rdata in-order response, one per accepted request
//   redirect_valid/_pc    flush and restart fetch at redirect_pc
//   inst_valid/_data/_pc  buffer head presented to decode
//   inst_ready            decode consumes head when inst_valid && inst_ready
//   perf_fetches/flushes  (IFU_PERF_CNT_EN only) pushed responses / redirects
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_flushes
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & WORD_MASK;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      fetch_addr_reg, fetch_addr_next;
  logic             mem_req_reg, mem_req_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;

  logic [31:0] buf_data_reg [BUF_DEPTH];
  logic [31:0] buf_pc_reg   [BUF_DEPTH];

  logic redirect_take;
  logic accept;
  logic push;
  logic pop;

  // A redirect in IDLE is ignored; everywhere else it wins over all other
  // activity, so the same-cycle push and pop are both suppressed.
  assign redirect_take = redirect_valid && (state_reg != IDLE);
  assign accept        = mem_req_reg && mem_ready;
  assign push          = (state_reg == WAIT) && mem_rvalid && !redirect_take;
  assign pop           = inst_valid && inst_ready && !redirect_take;

  // Control and program counter
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    fetch_addr_next = fetch_addr_reg;
    case (state_reg)
      IDLE: state_next = RUN;
      RUN: begin
        if (redirect_take) begin
          // A request accepted on the redirect edge is still in flight and
          // its response must be swallowed.
          state_next = accept ? DRAIN : RUN;
        end else if (accept) begin
          state_next      = WAIT;
          pc_next         = pc_reg + 32'd4;
          fetch_addr_next = pc_reg;
        end
      end
      WAIT: begin
        if (redirect_take) begin
          state_next = mem_rvalid ? RUN : DRAIN;
        end else if (mem_rvalid) begin
          state_next = RUN;
        end
      end
      DRAIN: begin
        // The stale response arriving resolves the drain even when another
        // redirect lands on the same edge; nothing else is outstanding.
        if (mem_rvalid) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
    if (redirect_take) begin
      pc_next = redirect_pc & WORD_MASK;
    end
  end

  // Buffer bookkeeping
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (redirect_take) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
    // Request is registered from next-state values. Space is reserved at
    // issue, so a full buffer holds the request off.
    mem_req_next = (state_next == RUN) && (count_next < DEPTH_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC_ALIGNED;
      fetch_addr_reg <= '0;
      mem_req_reg    <= 1'b0;
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      fetch_addr_reg <= fetch_addr_next;
      mem_req_reg    <= mem_req_next;
      count_reg      <= count_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
    end
  end

  // Storage is small and read combinationally at the head so a push at edge N
  // is visible to decode right after edge N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data_reg[i] <= '0;
        buf_pc_reg[i]   <= '0;
      end
    end else if (push) begin
      buf_data_reg[wr_ptr_reg] <= mem_rdata;
      buf_pc_reg[wr_ptr_reg]   <= fetch_addr_reg;
    end
  end

  assign mem_req    = mem_req_reg;
  assign mem_addr   = pc_reg;
  assign inst_valid = (count_reg != '0);
  assign inst_data  = buf_data_reg[rd_ptr_reg];
  assign inst_pc    = buf_pc_reg[rd_ptr_reg];

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetches_reg;
  logic [31:0] perf_flushes_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetches_reg <= '0;
      perf_flushes_reg <= '0;
    end else begin
      if (push)          perf_fetches_reg <= perf_fetches_reg + 32'd1;
      if (redirect_take) perf_flushes_reg <= perf_flushes_reg + 32'd1;
    end
  end

  assign perf_fetches = perf_fetches_reg;
  assign perf_flushes = perf_flushes_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;
  localparam logic [31:0] WMASK  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a memory that remembers its one in-flight request, plus
  // the list of instructions decode should still receive, in order.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t      exp_q[$];
  entry_t      mon_e;
  logic [31:0] model_pc;
  bit          outstanding;
  bit          out_drop;
  logic [31:0] out_addr;
  int          wait_cnt;
  int          accept_cnt;
  logic [31:0] last_accept, prev_accept;
  int          snap_cnt;
  bit          live;
  bit          drv_rv, drv_rd, drv_acc;

  // Stimulus knobs, changed by the sequence mid-cycle
  int          mem_ready_pct   = 100;
  int          inst_ready_mode = 1;   // 0 low, 1 high, 2 random, 3 high once
  int          inst_ready_pct  = 50;
  int          redirect_pct    = 0;
  bit          redirect_pending = 0;
  logic [31:0] redirect_target = '0;
  int          delay_min = 1, delay_max = 1;

  event drv_done;

  // True once an edge has passed with reset released
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  task automatic reset_model();
    exp_q.delete();
    model_pc         = RST_PC & WMASK;
    outstanding      = 0;
    out_drop         = 0;
    out_addr         = '0;
    wait_cnt         = 0;
    accept_cnt       = 0;
    snap_cnt         = 0;
    redirect_pending = 0;
    mem_ready        = 1'b0;
    mem_rvalid       = 1'b0;
    mem_rdata        = '0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    inst_ready       = 1'b0;
  endtask

  // Driver: at each falling edge, check request outputs against the model,
  // choose the inputs for the coming rising edge and record what that edge
  // is expected to do.
  initial begin
    reset_model();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        reset_model();
      end else begin
        snap_cnt = exp_q.size();
        if (live) check32("mem_req", 32'(mem_req), 32'(!outstanding && (exp_q.size() < DEPTH)));
        else      check32("mem_req_idle", 32'(mem_req), 32'd0);
        if (mem_req) check32("mem_addr", mem_addr, model_pc);

        drv_rv = outstanding && (wait_cnt == 0);
        if (outstanding && !drv_rv) wait_cnt--;
        drv_rd = live && (redirect_pending || ($urandom_range(99) < redirect_pct));

        mem_ready = ($urandom_range(99) < mem_ready_pct);
        case (inst_ready_mode)
          0: inst_ready = 1'b0;
          1: inst_ready = 1'b1;
          2: inst_ready = ($urandom_range(99) < inst_ready_pct);
          default: begin
            inst_ready = 1'b1;
            inst_ready_mode = 0;
          end
        endcase
        redirect_valid = drv_rd;
        redirect_pc    = redirect_pending ? redirect_target : $urandom();
        if (drv_rd) redirect_pending = 0;
        mem_rvalid = drv_rv;
        mem_rdata  = drv_rv ? (out_addr ^ KEY) : $urandom();

        drv_acc = mem_req && mem_ready;
        if (drv_rv) begin
          if (!out_drop && !drv_rd) exp_q.push_back(entry_t'({out_addr, out_addr ^ KEY}));
          outstanding = 0;
        end
        if (drv_rd) exp_q.delete();
        if (drv_acc) begin
          outstanding = 1;
          out_addr    = mem_addr;
          out_drop    = 0;
          wait_cnt    = int'($urandom_range(delay_max, delay_min)) - 1;
          model_pc    = model_pc + 32'd4;
          accept_cnt++;
          prev_accept = last_accept;
          last_accept = mem_addr;
        end
        if (drv_rd) begin
          model_pc = redirect_pc & WMASK;
          if (outstanding) out_drop = 1;
        end
      end
      -> drv_done;
    end
  end

  // Monitor: whenever decode takes the head, compare it with the oldest
  // expected instruction.
  initial begin
    forever begin
      @(drv_done);
      if (rst_n) begin
        check32("inst_valid", 32'(inst_valid), 32'(snap_cnt != 0));
        if (inst_valid && inst_ready && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            check32("unexpected_pop", 32'(inst_valid), 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check32("inst_pc", inst_pc, mon_e.pc);
            check32("inst_data", inst_data, mon_e.data);
            $display("pop pc=%h data=%h", inst_pc, inst_data);
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int a0;
  logic [31:0] addr0;

  initial begin
    #12;
    check32("rst_mem_req", 32'(mem_req), 32'd0);
    check32("rst_mem_addr", mem_addr, RST_PC);
    check32("rst_inst_valid", 32'(inst_valid), 32'd0);
    check32("rst_inst_data", inst_data, 32'd0);
    check32("rst_inst_pc", inst_pc, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Single-cycle memory, decode always ready: one fetch every 2 cycles
    cycles(20);
    check32("throughput", 32'(accept_cnt), 32'd10);

    // Empty the pipe, then fill with decode stalled
    mem_ready_pct = 0; inst_ready_mode = 1;
    cycles(10);
    a0 = accept_cnt; mem_ready_pct = 100; inst_ready_mode = 0;
    cycles(30);
    check32("fill_accepts", 32'(accept_cnt - a0), 32'(DEPTH));
    a0 = accept_cnt; inst_ready_mode = 3;
    cycles(20);
    check32("one_pop_accept", 32'(accept_cnt - a0), 32'd1);

    // Memory stall: request held stable
    inst_ready_mode = 1; mem_ready_pct = 0;
    cycles(8);
    check32("stall_req", 32'(mem_req), 32'd1);
    addr0 = mem_addr;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      check32("stall_req_hold", 32'(mem_req), 32'd1);
      check32("stall_addr_hold", mem_addr, addr0);
    end
    a0 = accept_cnt; mem_ready_pct = 100;
    cycles(1);
    check32("stall_accept", 32'(accept_cnt - a0), 32'd1);
    check32("stall_accept_addr", last_accept, addr0);

    // Redirect while waiting, response 3 cycles after acceptance
    delay_min = 3; delay_max = 3;
    for (int i = 0; i < 20 && !(outstanding && wait_cnt == 2); i++) cycles(1);
    check32("wait_found", 32'(outstanding && wait_cnt == 2), 32'd1);
    redirect_target = 32'h0000_1003; redirect_pending = 1;
    cycles(1);
    check32("flush_empty", 32'(inst_valid), 32'd0);
    a0 = accept_cnt;
    for (int i = 0; i < 20 && accept_cnt == a0; i++) cycles(1);
    check32("redirect_addr", last_accept, 32'h0000_1000);

    // Redirect coinciding with a response and a pop
    delay_min = 2; delay_max = 2; inst_ready_mode = 0;
    for (int i = 0; i < 40 && !(exp_q.size() >= 1 && outstanding && wait_cnt == 0); i++) cycles(1);
    check32("coincide_found", 32'(exp_q.size() >= 1 && outstanding && wait_cnt == 0), 32'd1);
    redirect_target = 32'h2000_0040; redirect_pending = 1; inst_ready_mode = 3;
    cycles(1);
    check32("coincide_empty", 32'(inst_valid), 32'd0);
    check32("coincide_req", 32'(mem_req), 32'd1);
    check32("coincide_addr", mem_addr, 32'h2000_0040);

    // Address wrap at the top of memory
    delay_min = 1; delay_max = 1; inst_ready_mode = 1; mem_ready_pct = 0;
    cycles(4);
    redirect_target = 32'hFFFF_FFFC; redirect_pending = 1;
    cycles(4);
    a0 = accept_cnt; mem_ready_pct = 100;
    for (int i = 0; i < 20 && accept_cnt < a0 + 2; i++) cycles(1);
    check32("wrap_first", prev_accept, 32'hFFFF_FFFC);
    check32("wrap_second", last_accept, 32'h0000_0000);

    // Reset in the middle of a wait
    delay_min = 3; delay_max = 3;
    for (int i = 0; i < 20 && !(outstanding && wait_cnt == 2); i++) cycles(1);
    check32("rst_wait_found", 32'(outstanding), 32'd1);
    rst_n = 1'b0;
    #1;
    check32("midrst_mem_req", 32'(mem_req), 32'd0);
    check32("midrst_mem_addr", mem_addr, RST_PC);
    check32("midrst_inst_valid", 32'(inst_valid), 32'd0);
    check32("midrst_inst_data", inst_data, 32'd0);
    check32("midrst_inst_pc", inst_pc, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Randomised traffic
    mem_ready_pct = 70; inst_ready_mode = 2; inst_ready_pct = 60;
    redirect_pct = 5; delay_min = 1; delay_max = 3;
    cycles(1500);

    // Drain everything that was fetched
    redirect_pct = 0; mem_ready_pct = 0; inst_ready_mode = 1;
    cycles(15);
    check32("drain_empty", 32'(exp_q.size()), 32'd0);
    check32("drain_valid", 32'(inst_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
